// File: rtl/floating_point_add_sub_pipe.sv
// floating_point_add_sub_pipe: fully pipelined floating-point adder/subtractor
// with configurable exponent/fraction widths, round-to-nearest-even, denormal
// flush-to-zero and a tag carried alongside each operation. Fixed 4-clock
// latency, one operation per clock, no backpressure.
// Optional: define FP_ADD_SUB_FLAGS_EN to add flagsOut = {invalid, overflow,
// underflow, inexact}, aligned with dataOut.
module floating_point_add_sub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                   clkIn,
  input  logic                   rstIn,
  input  logic [EXP_W+MAN_W:0]   dataAIn,
  input  logic [EXP_W+MAN_W:0]   dataBIn,
  input  logic                   subIn,
  input  logic [TAG_W-1:0]       tagIn,
  input  logic                   validIn,
  output logic [EXP_W+MAN_W:0]   dataOut,
  output logic [TAG_W-1:0]       tagOut,
  output logic                   validOut
`ifdef FP_ADD_SUB_FLAGS_EN
  ,
  output logic [3:0]             flagsOut
`endif
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int SW  = MAN_W + 4;             // hidden + fraction + guard/round/sticky
  localparam int LZW = $clog2(MAN_W + 5);
  localparam int XE  = EXP_W + LZW + 2;       // signed exponent with headroom for normalisation
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [XE-1:0] EXP_MAX = XE'((1 << EXP_W) - 1);

  // ---------------- input capture ----------------
  logic [W-1:0]     in_a_reg, in_b_reg;
  logic             in_sub_reg, in_valid_reg;
  logic [TAG_W-1:0] in_tag_reg;

  // register the raw operands so every stage starts from a clean edge
  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      in_a_reg <= '0; in_b_reg <= '0; in_sub_reg <= 1'b0; in_tag_reg <= '0; in_valid_reg <= 1'b0;
    end else begin
      in_a_reg <= dataAIn; in_b_reg <= dataBIn; in_sub_reg <= subIn;
      in_tag_reg <= tagIn; in_valid_reg <= validIn;
    end
  end

  // ---------------- stage 1: unpack, classify, swap ----------------
  logic             a_sign, b_sign, a_inf, b_inf, a_nan, b_nan, swap;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_frac, b_frac;
  logic             special_next;
  logic [W-1:0]     special_val_next;

  // decode operands, flush denormals, resolve inf/NaN cases, pick the larger magnitude
  always_comb begin
    a_sign = in_a_reg[W-1];
    b_sign = in_b_reg[W-1] ^ in_sub_reg;
    a_exp  = in_a_reg[W-2:MAN_W];
    b_exp  = in_b_reg[W-2:MAN_W];
    a_frac = (a_exp == '0) ? '0 : in_a_reg[MAN_W-1:0];
    b_frac = (b_exp == '0) ? '0 : in_b_reg[MAN_W-1:0];
    a_inf  = (&a_exp) && (a_frac == '0);
    b_inf  = (&b_exp) && (b_frac == '0);
    a_nan  = (&a_exp) && (a_frac != '0);
    b_nan  = (&b_exp) && (b_frac != '0);
    swap   = {b_exp, b_frac} > {a_exp, a_frac};
    special_next = a_nan || b_nan || a_inf || b_inf;
    if (a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign)))
      special_val_next = QNAN;
    else if (a_inf)
      special_val_next = {a_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else
      special_val_next = {b_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  end

  logic             s1_valid_reg, s1_x_sign_reg, s1_y_sign_reg, s1_special_reg;
  logic [TAG_W-1:0] s1_tag_reg;
  logic [EXP_W-1:0] s1_x_exp_reg, s1_y_exp_reg;
  logic [MAN_W:0]   s1_x_man_reg, s1_y_man_reg;
  logic [W-1:0]     s1_special_val_reg;

  // stage 1 register: X is the larger-magnitude operand, hidden bit restored
  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      s1_valid_reg <= 1'b0; s1_tag_reg <= '0; s1_x_sign_reg <= 1'b0; s1_y_sign_reg <= 1'b0;
      s1_x_exp_reg <= '0; s1_y_exp_reg <= '0; s1_x_man_reg <= '0; s1_y_man_reg <= '0;
      s1_special_reg <= 1'b0; s1_special_val_reg <= '0;
    end else begin
      s1_valid_reg       <= in_valid_reg;
      s1_tag_reg         <= in_tag_reg;
      s1_x_sign_reg      <= swap ? b_sign : a_sign;
      s1_y_sign_reg      <= swap ? a_sign : b_sign;
      s1_x_exp_reg       <= swap ? b_exp : a_exp;
      s1_y_exp_reg       <= swap ? a_exp : b_exp;
      s1_x_man_reg       <= swap ? {|b_exp, b_frac} : {|a_exp, a_frac};
      s1_y_man_reg       <= swap ? {|a_exp, a_frac} : {|b_exp, b_frac};
      s1_special_reg     <= special_next;
      s1_special_val_reg <= special_val_next;
    end
  end

  // ---------------- stage 2: align ----------------
  logic [EXP_W-1:0] align_shift;
  logic [SW-1:0]    y_ext, y_aligned, lost_mask;

  // shift Y right by the exponent difference, folding shifted-out bits into sticky
  always_comb begin
    align_shift = s1_x_exp_reg - s1_y_exp_reg;
    y_ext       = {s1_y_man_reg, 3'b000};
    lost_mask   = '0;
    y_aligned   = y_ext >> align_shift;
    if (32'(align_shift) >= 32'(MAN_W + 3)) begin
      y_aligned = {{(SW-1){1'b0}}, |s1_y_man_reg};
    end else begin
      lost_mask    = ~({SW{1'b1}} << align_shift);
      y_aligned[0] = y_aligned[0] | (|(y_ext & lost_mask));
    end
  end

  logic             s2_valid_reg, s2_x_sign_reg, s2_y_sign_reg, s2_special_reg;
  logic [TAG_W-1:0] s2_tag_reg;
  logic [EXP_W-1:0] s2_exp_reg;
  logic [SW-1:0]    s2_x_sig_reg, s2_y_sig_reg;
  logic [W-1:0]     s2_special_val_reg;

  // stage 2 register: both significands now share X's exponent
  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      s2_valid_reg <= 1'b0; s2_tag_reg <= '0; s2_x_sign_reg <= 1'b0; s2_y_sign_reg <= 1'b0;
      s2_exp_reg <= '0; s2_x_sig_reg <= '0; s2_y_sig_reg <= '0;
      s2_special_reg <= 1'b0; s2_special_val_reg <= '0;
    end else begin
      s2_valid_reg       <= s1_valid_reg;
      s2_tag_reg         <= s1_tag_reg;
      s2_x_sign_reg      <= s1_x_sign_reg;
      s2_y_sign_reg      <= s1_y_sign_reg;
      s2_exp_reg         <= s1_x_exp_reg;
      s2_x_sig_reg       <= {s1_x_man_reg, 3'b000};
      s2_y_sig_reg       <= y_aligned;
      s2_special_reg     <= s1_special_reg;
      s2_special_val_reg <= s1_special_val_reg;
    end
  end

  // ---------------- stage 3: add / subtract ----------------
  logic [SW:0] sum_next;
  // |X| >= |Y| so the difference never goes negative
  assign sum_next = (s2_x_sign_reg != s2_y_sign_reg) ? ({1'b0, s2_x_sig_reg} - {1'b0, s2_y_sig_reg})
                                                      : ({1'b0, s2_x_sig_reg} + {1'b0, s2_y_sig_reg});

  logic             s3_valid_reg, s3_sign_reg, s3_zero_sign_reg, s3_special_reg;
  logic [TAG_W-1:0] s3_tag_reg;
  logic [EXP_W-1:0] s3_exp_reg;
  logic [SW:0]      s3_sum_reg;
  logic [W-1:0]     s3_special_val_reg;

  // stage 3 register: raw sum; an exact zero is only negative for (-0)+(-0)
  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      s3_valid_reg <= 1'b0; s3_tag_reg <= '0; s3_sign_reg <= 1'b0; s3_zero_sign_reg <= 1'b0;
      s3_exp_reg <= '0; s3_sum_reg <= '0; s3_special_reg <= 1'b0; s3_special_val_reg <= '0;
    end else begin
      s3_valid_reg       <= s2_valid_reg;
      s3_tag_reg         <= s2_tag_reg;
      s3_sign_reg        <= s2_x_sign_reg;
      s3_zero_sign_reg   <= s2_x_sign_reg & s2_y_sign_reg;
      s3_exp_reg         <= s2_exp_reg;
      s3_sum_reg         <= sum_next;
      s3_special_reg     <= s2_special_reg;
      s3_special_val_reg <= s2_special_val_reg;
    end
  end

  // ---------------- stage 4: normalise, round, pack ----------------
  logic [LZW-1:0]        lz;
  logic                  lz_found, rnd_up, rnd_carry, res_zero, res_ovf, res_unf;
  logic [SW-1:0]         norm;
  logic signed [XE-1:0]  exp_norm, exp_final;
  logic [MAN_W-1:0]      frac_rnd;
  logic [W-1:0]          result;

  // leading-zero normalise (or 1-bit right shift on carry), RNE round, then pick special results
  always_comb begin
    lz = '0;
    lz_found = 1'b0;
    for (int i = SW - 1; i >= 0; i--) begin
      if (!lz_found) begin
        if (s3_sum_reg[i]) lz_found = 1'b1;
        else               lz = lz + LZW'(1);
      end
    end
    if (s3_sum_reg[SW]) begin
      norm     = {s3_sum_reg[SW:2], s3_sum_reg[1] | s3_sum_reg[0]};
      exp_norm = XE'(s3_exp_reg) + XE'(1);
    end else begin
      norm     = s3_sum_reg[SW-1:0] << lz;
      exp_norm = XE'(s3_exp_reg) - XE'(lz);
    end
    rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    {rnd_carry, frac_rnd} = {1'b0, norm[SW-2:3]} + (MAN_W+1)'(rnd_up);
    exp_final = exp_norm + XE'(rnd_carry);
    res_zero  = !norm[SW-1];
    res_ovf   = !s3_special_reg && !res_zero && (exp_final >= EXP_MAX);
    res_unf   = !s3_special_reg && !res_zero && (exp_final[XE-1] || (exp_final == '0));
    if (s3_special_reg)  result = s3_special_val_reg;
    else if (res_zero)   result = {s3_zero_sign_reg, {(W-1){1'b0}}};
    else if (res_ovf)    result = {s3_sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (res_unf)    result = {s3_sign_reg, {(W-1){1'b0}}};
    else                 result = {s3_sign_reg, exp_final[EXP_W-1:0], frac_rnd};
  end

  // output register; reset forces all outputs to zero immediately
  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      dataOut <= '0; tagOut <= '0; validOut <= 1'b0;
    end else begin
      dataOut <= result; tagOut <= s3_tag_reg; validOut <= s3_valid_reg;
    end
  end

`ifdef FP_ADD_SUB_FLAGS_EN
  logic invalid_next, s1_inv_reg, s2_inv_reg, s3_inv_reg, res_inexact;
  assign invalid_next = (a_inf && b_inf && (a_sign != b_sign))
                      || (a_nan && !a_frac[MAN_W-1]) || (b_nan && !b_frac[MAN_W-1]);
  assign res_inexact  = !s3_special_reg && (norm[2] || norm[1] || norm[0] || res_ovf || res_unf);

  // exception flags travel with their operation and land with dataOut
  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      s1_inv_reg <= 1'b0; s2_inv_reg <= 1'b0; s3_inv_reg <= 1'b0; flagsOut <= '0;
    end else begin
      s1_inv_reg <= invalid_next;
      s2_inv_reg <= s1_inv_reg;
      s3_inv_reg <= s2_inv_reg;
      flagsOut   <= {s3_inv_reg, res_ovf, res_unf, res_inexact};
    end
  end
`endif

endmodule

// File: tb/tb_floating_point_add_sub_pipe.sv
// Self-checking bench for floating_point_add_sub_pipe: scoreboard of expected
// results (double-precision reference for random traffic), reset behaviour,
// latency/gap tracking and a half-precision instance.
module tb_floating_point_add_sub_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] a, b, dout;
  logic        sub, valid, vout;
  logic [3:0]  tag, tout;
  logic [15:0] ha, hb, hdout;
  logic        hsub, hvalid, hvout;
  logic [3:0]  htag, htout;
`ifdef FP_ADD_SUB_FLAGS_EN
  logic [3:0]  fout, hfout;
`endif

  floating_point_add_sub_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .clkIn(clk), .rstIn(rst_n), .dataAIn(a), .dataBIn(b), .subIn(sub), .tagIn(tag),
    .validIn(valid), .dataOut(dout), .tagOut(tout), .validOut(vout)
`ifdef FP_ADD_SUB_FLAGS_EN
    , .flagsOut(fout)
`endif
  );

  floating_point_add_sub_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut_half (
    .clkIn(clk), .rstIn(rst_n), .dataAIn(ha), .dataBIn(hb), .subIn(hsub), .tagIn(htag),
    .validIn(hvalid), .dataOut(hdout), .tagOut(htout), .validOut(hvout)
`ifdef FP_ADD_SUB_FLAGS_EN
    , .flagsOut(hfout)
`endif
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    int          issue;
    logic [3:0]  flags;
    bit          chk_flags;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // binary32 (normal) -> real, exact
  function automatic real sp2r(input logic [31:0] x);
    logic [63:0] d;
    d = {x[31], 11'(int'(x[30:23]) + 896), x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // real -> binary32 with round-to-nearest-even (normal range only)
  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [52:0] m;
    logic [23:0] m24;
    logic [28:0] rest;
    int          e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'h0000_0000;
    e    = int'(d[62:52]) - 896;
    m    = {1'b1, d[51:0]};
    m24  = m[52:29];
    rest = m[28:0];
    if (rest > 29'h1000_0000 || (rest == 29'h1000_0000 && m24[0])) m24 = m24 + 24'd1;
    if (m24 == 24'd0) begin
      m24 = 24'h80_0000;
      e   = e + 1;
    end
    return {d[63], e[7:0], m24[22:0]};
  endfunction

  task automatic issue(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                       input logic [3:0] tt, input logic [31:0] ed, input logic [3:0] ef,
                       input bit cf);
    exp_t e;
    @(negedge clk);
    a = ta; b = tb_v; sub = ts; tag = tt; valid = 1'b1;
    e.data = ed; e.tag = tt; e.issue = cyc + 1; e.flags = ef; e.chk_flags = cf;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid = 1'b0;
    end
  endtask

  // scoreboard side: every valid result must match the oldest pending expectation
  always @(negedge clk) begin
    if (rst_n && vout) begin
      if (sb_q.size() == 0) begin
        check("spurious_valid", vout, 1'b0);
      end else begin
        mon_e = sb_q.pop_front();
        $display("[TB] out tag=%0d data=%h cycle=%0d", tout, dout, cyc);
        check("data", dout, mon_e.data);
        check("tag", tout, mon_e.tag);
        check("latency", cyc, mon_e.issue + 4);
`ifdef FP_ADD_SUB_FLAGS_EN
        if (mon_e.chk_flags) check("flags", fout, mon_e.flags);
`endif
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    real         rr;
    rst_n = 1'b0; a = '0; b = '0; sub = 1'b0; tag = '0; valid = 1'b0;
    ha = '0; hb = '0; hsub = 1'b0; htag = '0; hvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", vout, 1'b0);
    check("reset_data", dout, 32'h0);
    check("reset_tag", tout, 4'h0);
`ifdef FP_ADD_SUB_FLAGS_EN
    check("reset_flags", fout, 4'h0);
`endif
    rst_n = 1'b1;

    // directed single-precision cases
    issue(32'h3F80_0000, 32'h4000_0000, 1'b0, 4'd5,  32'h4040_0000, 4'b0000, 1'b1);
    issue(32'h4049_0FDB, 32'h4049_0FDB, 1'b1, 4'd1,  32'h0000_0000, 4'b0000, 1'b1);
    issue(32'h3F80_0000, 32'h3380_0000, 1'b0, 4'd2,  32'h3F80_0000, 4'b0001, 1'b1);
    issue(32'h3F80_0001, 32'h3380_0000, 1'b0, 4'd3,  32'h3F80_0002, 4'b0001, 1'b1);
    issue(32'h7F80_0000, 32'hFF80_0000, 1'b0, 4'd4,  32'h7FC0_0000, 4'b1000, 1'b1);
    issue(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 4'd6,  32'h7F80_0000, 4'b0101, 1'b1);
    issue(32'h0040_0000, 32'h0000_0000, 1'b0, 4'd7,  32'h0000_0000, 4'b0000, 1'b1);
    issue(32'h8000_0000, 32'h8000_0000, 1'b0, 4'd8,  32'h8000_0000, 4'b0000, 1'b1);
    issue(32'h7F80_0001, 32'h0000_0000, 1'b0, 4'd9,  32'h7FC0_0000, 4'b1000, 1'b1);
    issue(32'h7FC0_0000, 32'h3F80_0000, 1'b0, 4'd10, 32'h7FC0_0000, 4'b0000, 1'b1);
    issue(32'h7F80_0000, 32'h3F80_0000, 1'b1, 4'd11, 32'h7F80_0000, 4'b0000, 1'b1);
    issue(32'h3F80_0000, 32'h3FC0_0000, 1'b1, 4'd12, 32'hBF00_0000, 4'b0000, 1'b1);
    idle(6);

    // streaming random traffic with a 3-cycle gap in the middle
    for (int i = 0; i < 100; i++) begin
      ra = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 144)), 23'($urandom)};
      rb = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 144)), 23'($urandom)};
      rs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) rb = ra;
      rr = sp2r(ra) + (rs ? -sp2r(rb) : sp2r(rb));
      issue(ra, rb, rs, 4'(i), r2sp(rr), 4'b0000, 1'b0);
      if (i == 49) idle(3);
    end
    idle(8);

    // reset mid-flight: two ops in the pipe, third driven while reset is low
    issue(32'h3F80_0000, 32'h3F80_0000, 1'b0, 4'd1, 32'h4000_0000, 4'b0000, 1'b0);
    issue(32'h4000_0000, 32'h4000_0000, 1'b0, 4'd2, 32'h4080_0000, 4'b0000, 1'b0);
    @(negedge clk);
    a = 32'h4040_0000; b = 32'h4040_0000; tag = 4'd3; valid = 1'b1;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("midrst_valid", vout, 1'b0);
    check("midrst_data", dout, 32'h0);
    check("midrst_tag", tout, 4'h0);
    @(negedge clk);
    rst_n = 1'b1; valid = 1'b0;
    idle(2);
    issue(32'h3F80_0000, 32'h4000_0000, 1'b0, 4'd13, 32'h4040_0000, 4'b0000, 1'b1);
    idle(8);

    // half precision instance
    @(negedge clk);
    ha = 16'h3C00; hb = 16'h4000; htag = 4'd1; hvalid = 1'b1;
    @(negedge clk);
    ha = 16'h7BFF; hb = 16'h7BFF; htag = 4'd2;
    @(negedge clk);
    hvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("half_valid0", hvout, 1'b1);
    check("half_add", hdout, 16'h4200);
    check("half_tag0", htout, 4'd1);
`ifdef FP_ADD_SUB_FLAGS_EN
    check("half_flags0", hfout, 4'b0000);
`endif
    @(negedge clk);
    check("half_valid1", hvout, 1'b1);
    check("half_ovf", hdout, 16'h7C00);
    check("half_tag1", htout, 4'd2);
`ifdef FP_ADD_SUB_FLAGS_EN
    check("half_flags1", hfout, 4'b0101);
`endif
    @(negedge clk);
    check("half_valid2", hvout, 1'b0);

    check("drain", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
